// File: rtl/rv_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rv_pkg : shared memory-op and LSU types for the core.            |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package rv_pkg;

   typedef enum logic [1:0] {
      BYTE = 2'd0,
      HALF = 2'd1,
      WORD = 2'd2
   } mem_op_sz_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR_WAIT = 2'd2,
      RESP    = 2'd3
   } lsu_state_e;

   typedef enum logic [1:0] {
      OK       = 2'b00,
      MISALIGN = 2'b01,
      TIMEOUT  = 2'b10
   } lsu_err_e;

   localparam int LSU_TIMEOUT_DEFAULT = 1023;

   function automatic logic is_misaligned(input mem_op_sz_e size, input logic [1:0] addr_lo);
      case (size)
         HALF:    return addr_lo[0];
         WORD:    return addr_lo != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_ext.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lsu_load_ext : size-dependent sign/zero extension of load data.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module lsu_load_ext
   import rv_pkg::*;
(
   input  logic [31:0] data,
   input  mem_op_sz_e  size,
   input  logic        is_unsigned,
   output logic [31:0] result
);

   always_comb begin
      result = data;
      case (size)
         BYTE:    result = {{24{~is_unsigned & data[7]}},  data[7:0]};
         HALF:    result = {{16{~is_unsigned & data[15]}}, data[15:0]};
         default: result = data;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/ddr3_lsu_master.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ddr3_lsu_master : single-outstanding load/store initiator for    |
// | the ddr3 CPU port. Optional wait timeout: DDR3_LSU_TIMEOUT_EN.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module ddr3_lsu_master
   import rv_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req_valid,
   input  logic        i_req_we,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   input  mem_op_sz_e  i_req_size,
   input  logic        i_req_unsigned,
   output logic        o_req_ready,
   output logic        o_rsp_valid,
   output logic [31:0] o_rsp_rdata,
   output logic [1:0]  o_rsp_err,
   output logic        o_we,
   output logic        o_re,
   output logic [31:0] o_addr,
   output logic [31:0] o_data,
   output mem_op_sz_e  o_mem_size,
   input  logic [31:0] i_data,
   input  logic        i_data_ready,
   input  logic        i_write_ready
);

   lsu_state_e  r_state, w_state_d;
   logic        r_uns, w_uns_d;
   logic        w_re_d, w_we_d, w_rsp_valid_d;
   logic [31:0] w_addr_d, w_data_d, w_rsp_rdata_d, w_ext;
   mem_op_sz_e  w_size_d;
   lsu_err_e    w_err_d;
   logic        w_timeout;

`ifdef DDR3_LSU_TIMEOUT_EN
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CW-1:0] r_cnt;

   // Counts wait cycles; zero whenever not waiting, so each wait starts fresh.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_cnt <= '0;
      else if (r_state == RD_WAIT || r_state == WR_WAIT)
         r_cnt <= r_cnt + CW'(1);
      else
         r_cnt <= '0;
   end

   assign w_timeout = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
   logic [31:0] w_unused_timeout_cfg;
   assign w_unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
   assign w_timeout = 1'b0;
`endif

   lsu_load_ext u_load_ext (
      .data        (i_data),
      .size        (o_mem_size),
      .is_unsigned (r_uns),
      .result      (w_ext)
   );

   assign o_req_ready = (r_state == IDLE);

   always_comb begin
      w_state_d     = r_state;
      w_re_d        = o_re;
      w_we_d        = o_we;
      w_addr_d      = o_addr;
      w_data_d      = o_data;
      w_size_d      = o_mem_size;
      w_uns_d       = r_uns;
      w_rsp_valid_d = 1'b0;
      w_rsp_rdata_d = 32'h0;
      w_err_d       = OK;
      case (r_state)
         IDLE: begin
            if (i_req_valid) begin
               w_addr_d = i_req_addr;
               w_data_d = i_req_wdata;
               w_size_d = i_req_size;
               w_uns_d  = i_req_unsigned;
               if (is_misaligned(i_req_size, i_req_addr[1:0])) begin
                  w_state_d     = RESP;
                  w_rsp_valid_d = 1'b1;
                  w_err_d       = MISALIGN;
               end else if (i_req_we) begin
                  w_state_d = WR_WAIT;
                  w_we_d    = 1'b1;
               end else begin
                  w_state_d = RD_WAIT;
                  w_re_d    = 1'b1;
               end
            end
         end
         RD_WAIT: begin
            // A ready in the expiry cycle takes priority over the timeout.
            if (i_data_ready) begin
               w_state_d     = RESP;
               w_re_d        = 1'b0;
               w_rsp_valid_d = 1'b1;
               w_rsp_rdata_d = w_ext;
            end else if (w_timeout) begin
               w_state_d     = RESP;
               w_re_d        = 1'b0;
               w_rsp_valid_d = 1'b1;
               w_err_d       = TIMEOUT;
            end
         end
         WR_WAIT: begin
            if (i_write_ready) begin
               w_state_d     = RESP;
               w_we_d        = 1'b0;
               w_rsp_valid_d = 1'b1;
            end else if (w_timeout) begin
               w_state_d     = RESP;
               w_we_d        = 1'b0;
               w_rsp_valid_d = 1'b1;
               w_err_d       = TIMEOUT;
            end
         end
         default: w_state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_uns       <= 1'b0;
         o_re        <= 1'b0;
         o_we        <= 1'b0;
         o_addr      <= 32'h0;
         o_data      <= 32'h0;
         o_mem_size  <= WORD;
         o_rsp_valid <= 1'b0;
         o_rsp_rdata <= 32'h0;
         o_rsp_err   <= 2'b00;
      end else begin
         r_state     <= w_state_d;
         r_uns       <= w_uns_d;
         o_re        <= w_re_d;
         o_we        <= w_we_d;
         o_addr      <= w_addr_d;
         o_data      <= w_data_d;
         o_mem_size  <= w_size_d;
         o_rsp_valid <= w_rsp_valid_d;
         o_rsp_rdata <= w_rsp_rdata_d;
         o_rsp_err   <= w_err_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ddr3_lsu_master.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | tb_ddr3_lsu_master : randomized self-checking bench.             |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_ddr3_lsu_master;
   import rv_pkg::*;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
   logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
   mem_op_sz_e  req_size = WORD;
   logic        req_ready, rsp_valid;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_err;
   logic        ddr_we, ddr_re;
   logic [31:0] ddr_addr, ddr_wdata;
   mem_op_sz_e  ddr_size;
   logic [31:0] ddr_rdata = 32'h0;
   logic        data_ready = 1'b0, write_ready = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   ddr3_lsu_master #(.TIMEOUT_CYCLES(TO)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(req_valid), .i_req_we(req_we), .i_req_addr(req_addr),
      .i_req_wdata(req_wdata), .i_req_size(req_size), .i_req_unsigned(req_unsigned),
      .o_req_ready(req_ready), .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata),
      .o_rsp_err(rsp_err), .o_we(ddr_we), .o_re(ddr_re), .o_addr(ddr_addr),
      .o_data(ddr_wdata), .o_mem_size(ddr_size), .i_data(ddr_rdata),
      .i_data_ready(data_ready), .i_write_ready(write_ready)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_ext(input logic [31:0] d, input mem_op_sz_e sz, input bit uns);
      int v;
      if (sz == BYTE) begin
         v = int'(d % 256);
         if (!uns && v >= 128) v = v - 256;
         return 32'(v);
      end else if (sz == HALF) begin
         v = int'(d % 65536);
         if (!uns && v >= 32768) v = v - 65536;
         return 32'(v);
      end
      return d;
   endfunction

   // delay: index of the strobe cycle carrying the ready, negative = never.
   task automatic do_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input mem_op_sz_e sz, input bit uns, input int delay,
                         input logic [31:0] rdata, input bit stray);
      bit          mis, timed_out;
      int          n_strobe, exp_strobe;
      logic [31:0] exp_rd;
      logic [1:0]  exp_err;
      mis = (sz == HALF && addr % 2 != 0) || (sz == WORD && addr % 4 != 0);
      check("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
      req_size = sz; req_unsigned = uns;
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (mis) begin
         check("mis_no_strobe", 32'({ddr_re, ddr_we}), 32'd0);
         exp_rd  = 32'h0;
         exp_err = 2'b01;
      end else begin
`ifdef DDR3_LSU_TIMEOUT_EN
         timed_out = (delay < 0 || delay >= TO);
`else
         timed_out = 1'b0;
`endif
         exp_strobe = timed_out ? TO : delay + 1;
         n_strobe = 0;
         for (int w = 0; w < 64; w++) begin
            if (we ? ddr_we : ddr_re) begin
               n_strobe++;
               check("other_strobe", 32'(we ? ddr_re : ddr_we), 32'd0);
               check("addr", ddr_addr, addr);
               check("size", 32'(ddr_size), 32'(sz));
               if (we) check("wdata", ddr_wdata, wdata);
            end
            if (w == delay) begin
               if (we) write_ready = 1'b1;
               else begin data_ready = 1'b1; ddr_rdata = rdata; end
            end
            if (stray && $urandom_range(1, 0) == 1) begin
               if (we) begin data_ready = 1'b1; ddr_rdata = $urandom; end
               else write_ready = 1'b1;
            end
            @(posedge clk); #1;
            data_ready = 1'b0; write_ready = 1'b0;
            if (!(ddr_re || ddr_we)) break;
         end
         check("strobe_cycles", 32'(n_strobe), 32'(exp_strobe));
         exp_rd  = (we || timed_out) ? 32'h0 : model_ext(rdata, sz, uns);
         exp_err = timed_out ? 2'b10 : 2'b00;
      end
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_err", 32'(rsp_err), 32'(exp_err));
      check("rsp_rdata", rsp_rdata, exp_rd);
      check("strobe_low_resp", 32'({ddr_re, ddr_we}), 32'd0);
      check("req_ready_resp", 32'(req_ready), 32'd0);
      if ($urandom_range(1, 0) == 1) begin data_ready = 1'b1; write_ready = 1'b1; end
      @(posedge clk); #1;
      data_ready = 1'b0; write_ready = 1'b0;
      check("rsp_single", 32'(rsp_valid), 32'd0);
      check("strobe_low_idle", 32'({ddr_re, ddr_we}), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ctl"}, 32'({ddr_re, ddr_we, rsp_valid}), 32'd0);
      check({tag, "_rdata"}, rsp_rdata, 32'h0);
      check({tag, "_err"}, 32'(rsp_err), 32'd0);
      check({tag, "_addr"}, ddr_addr, 32'h0);
      check({tag, "_data"}, ddr_wdata, 32'h0);
      check({tag, "_size"}, 32'(ddr_size), 32'(WORD));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      #2 rst = 1'b1;
      #1 check_reset_outputs("reset");
      @(posedge clk); @(posedge clk); #2 rst = 1'b0;
      @(posedge clk); #1;
      check("ready_after_reset", 32'(req_ready), 32'd1);

      do_txn(1'b0, 32'h100, 32'h0, WORD, 1'b0, 2, 32'hDEADBEEF, 1'b0);
      do_txn(1'b0, 32'h203, 32'h0, BYTE, 1'b0, 0, 32'h00000080, 1'b0);
      do_txn(1'b0, 32'h203, 32'h0, BYTE, 1'b1, 1, 32'h00000080, 1'b0);
      do_txn(1'b0, 32'h202, 32'h0, HALF, 1'b0, 0, 32'h00008001, 1'b0);
      do_txn(1'b1, 32'h40, 32'h12345678, WORD, 1'b0, 0, 32'h0, 1'b1);
      do_txn(1'b1, 32'h44, 32'hCAFEF00D, WORD, 1'b0, 3, 32'h0, 1'b1);
      do_txn(1'b0, 32'h102, 32'h0, WORD, 1'b0, 0, 32'h0, 1'b0);
      do_txn(1'b1, 32'h101, 32'hAAAA5555, HALF, 1'b0, 0, 32'h0, 1'b0);

`ifdef DDR3_LSU_TIMEOUT_EN
      do_txn(1'b0, 32'h300, 32'h0, WORD, 1'b0, -1, 32'h0, 1'b0);
      do_txn(1'b1, 32'h304, 32'h11223344, WORD, 1'b0, -1, 32'h0, 1'b1);
      do_txn(1'b0, 32'h308, 32'h0, WORD, 1'b0, TO - 1, 32'h89ABCDEF, 1'b0);
      do_txn(1'b1, 32'h30C, 32'h55667788, WORD, 1'b0, TO - 1, 32'h0, 1'b0);
`endif

      // Reset in the middle of a read, then a late ready.
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h500; req_size = WORD; req_unsigned = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      check("re_before_reset", 32'(ddr_re), 32'd1);
      rst = 1'b1;
      #1 check_reset_outputs("midreset");
      data_ready = 1'b1; ddr_rdata = 32'h77777777;
      @(posedge clk); #2 rst = 1'b0;
      @(posedge clk); #1;
      data_ready = 1'b0;
      check("no_rsp_after_reset", 32'(rsp_valid), 32'd0);
      check("no_strobe_after_reset", 32'({ddr_re, ddr_we}), 32'd0);
      @(posedge clk); #1;
      check("no_rsp_after_reset2", 32'(rsp_valid), 32'd0);
      do_txn(1'b0, 32'h504, 32'h0, HALF, 1'b1, 1, 32'h0000F00F, 1'b1);

      for (int t = 0; t < 150; t++) begin
         logic [31:0] a;
         mem_op_sz_e  s;
         bit          w;
         a = $urandom;
         s = mem_op_sz_e'($urandom_range(2, 0));
         w = 1'($urandom_range(1, 0));
         do_txn(w, a, $urandom, s, 1'($urandom_range(1, 0)),
                int'($urandom_range(6, 0)), $urandom, 1'($urandom_range(1, 0)));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
